rifl_traffic_gen: RTL and testbench

RIFL_TRAFFIC_GEN -- requirements
Module: rifl_traffic_gen

---
 rtl/rifl_axis_if.sv | 11 +
 rtl/rifl_traffic_gen.sv | 153 +++++++++++++++
 tb/tb_rifl_traffic_gen.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rifl_axis_if.sv
// AXI4-Stream bundle carrying 14-byte beats from the traffic generator into the rifl s_axis port.
interface rifl_axis_if;
  logic [111:0] tdata;
  logic [13:0]  tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/rifl_traffic_gen.sv
// Packet traffic generator: emits sequenced, indexed AXI4-Stream packets with programmable length,
// last-beat keep, inter-packet gap and packet count.
module rifl_traffic_gen #(
  parameter logic [31:0] SEQ_INIT  = 32'd0,
  parameter int          MAX_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clr,
  input  logic [MAX_LEN_W-1:0] pkt_len_beats,
  input  logic [3:0]           last_keep_bytes,
  input  logic [7:0]           gap_cycles,
  input  logic [31:0]          pkt_target,
  rifl_axis_if.master          m_axis,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          pkts_sent,
  output logic [31:0]          beats_sent
);

  localparam int GC_W = 80 - MAX_LEN_W;
  localparam logic [MAX_LEN_W-1:0] LEN_ONE = MAX_LEN_W'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t               state, state_next;
  logic [31:0]          seq_num;
  logic [63:0]          global_cnt;
  logic [MAX_LEN_W-1:0] beat_idx;
  logic [MAX_LEN_W-1:0] len_q;
  logic [3:0]           keep_q;
  logic [7:0]           gap_q;
  logic [7:0]           gap_cnt;

  logic                 start_pkt;
  logic                 gap_load;
  logic                 hs;
  logic                 last_beat;
  logic                 clr_act;
  logic [31:0]          pkts_inc;
  logic [MAX_LEN_W-1:0] len_eff;
  logic [3:0]           keep_eff;
  logic [13:0]          last_mask;

  assign hs        = m_axis.tvalid && m_axis.tready;
  assign last_beat = (beat_idx == (len_q - LEN_ONE));
  assign clr_act   = clr && (state == IDLE || state == DONE);
  assign pkts_inc  = pkts_sent + 32'd1;
  assign len_eff   = (pkt_len_beats == '0) ? LEN_ONE : pkt_len_beats;
  assign keep_eff  = (last_keep_bytes == 4'd0 || last_keep_bytes > 4'd14) ? 4'd14 : last_keep_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A back-to-back packet stays in SEND and simply re-arms start_pkt on the last handshake.
  always_comb begin
    state_next = state;
    start_pkt  = 1'b0;
    gap_load   = 1'b0;
    case (state)
      IDLE: begin
        if (!clr && enable) begin
          state_next = SEND;
          start_pkt  = 1'b1;
        end
      end
      SEND: begin
        if (hs && last_beat) begin
          if (pkt_target != 32'd0 && pkts_inc == pkt_target) begin
            state_next = DONE;
          end else if (!enable) begin
            state_next = IDLE;
          end else if (gap_q != 8'd0) begin
            state_next = GAP;
            gap_load   = 1'b1;
          end else begin
            start_pkt  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= 8'd1) begin
          if (enable) begin
            state_next = SEND;
            start_pkt  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DONE: begin
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_num    <= SEQ_INIT;
      global_cnt <= '0;
      pkts_sent  <= '0;
      beats_sent <= '0;
      beat_idx   <= '0;
      len_q      <= LEN_ONE;
      keep_q     <= 4'd14;
      gap_q      <= '0;
      gap_cnt    <= '0;
    end else begin
      if (clr_act) begin
        seq_num    <= SEQ_INIT;
        global_cnt <= '0;
        pkts_sent  <= '0;
        beats_sent <= '0;
      end else if (hs) begin
        beats_sent <= beats_sent + 32'd1;
        global_cnt <= global_cnt + 64'd1;
        beat_idx   <= beat_idx + LEN_ONE;
        if (last_beat) begin
          pkts_sent <= pkts_inc;
          seq_num   <= seq_num + 32'd1;
        end
      end
      // Packet shape is captured once here so mid-packet input changes cannot corrupt framing.
      if (start_pkt) begin
        beat_idx <= '0;
        len_q    <= len_eff;
        keep_q   <= keep_eff;
        gap_q    <= gap_cycles;
      end
      if (gap_load)          gap_cnt <= gap_q;
      else if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
    end
  end

  always_comb begin
    last_mask = '0;
    for (int i = 0; i < 14; i++) last_mask[i] = (4'(i) < keep_q);
  end

  // Payload fields are gated by tvalid so the bus reads all-zero whenever nothing is offered.
  assign m_axis.tvalid = (state == SEND);
  assign m_axis.tlast  = m_axis.tvalid && last_beat;
  assign m_axis.tkeep  = !m_axis.tvalid ? 14'h0000 : (last_beat ? last_mask : 14'h3FFF);
  assign m_axis.tdata  = m_axis.tvalid ? {seq_num, beat_idx, GC_W'(global_cnt)} : 112'd0;

  assign busy = (state == SEND) || (state == GAP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rifl_traffic_gen.sv
// Directed self-checking bench for rifl_traffic_gen: one task per scenario, beats captured mid-cycle.
module tb_rifl_traffic_gen;

  localparam logic [31:0] SEQ_INIT = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clr;
  logic [15:0] pkt_len_beats;
  logic [3:0]  last_keep_bytes;
  logic [7:0]  gap_cycles;
  logic [31:0] pkt_target;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;
  logic [31:0] beats_sent;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [111:0] cap_data[$];
  logic [13:0]  cap_keep[$];
  logic         cap_last[$];
  int           cap_cyc[$];

  rifl_axis_if axis ();

  rifl_traffic_gen #(.SEQ_INIT(SEQ_INIT), .MAX_LEN_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .clr            (clr),
    .pkt_len_beats  (pkt_len_beats),
    .last_keep_bytes(last_keep_bytes),
    .gap_cycles     (gap_cycles),
    .pkt_target     (pkt_target),
    .m_axis         (axis),
    .busy           (busy),
    .done           (done),
    .pkts_sent      (pkts_sent),
    .beats_sent     (beats_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle capture of every beat that will handshake on the coming rising edge.
  always @(negedge clk) begin
    cyc++;
    if (axis.tvalid && axis.tready) begin
      cap_data.push_back(axis.tdata);
      cap_keep.push_back(axis.tkeep);
      cap_last.push_back(axis.tlast);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    cap_data.delete();
    cap_keep.delete();
    cap_last.delete();
    cap_cyc.delete();
  endtask

  task automatic configure(input logic [15:0] len, input logic [3:0] keep,
                           input logic [7:0] gap, input logic [31:0] target);
    pkt_len_beats   = len;
    last_keep_bytes = keep;
    gap_cycles      = gap;
    pkt_target      = target;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", axis.tvalid); end
    checks++; if (axis.tdata !== 112'd0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", axis.tdata); end
    checks++; if (axis.tkeep !== 14'h0) begin errors++; $display("[TB] FAIL reset_tkeep: got %h expected 0", axis.tkeep); end
    checks++; if (axis.tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b expected 0", axis.tlast); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy_done: got %b expected 00", {busy, done}); end
    checks++; if (pkts_sent !== 32'd0 || beats_sent !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", pkts_sent, beats_sent); end
    @(posedge clk); #1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [111:0] d;
    logic         exp_last;
    configure(16'd3, 4'd5, 8'd0, 32'd2);
    axis.tready = 1'b1;
    clear_capture();
    enable = 1'b1;
    step();
    checks++; if (axis.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: tvalid got %b expected 1", axis.tvalid); end
    for (int i = 0; i < 40 && !done; i++) step();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %b expected 1", done); end
    checks++; if (cap_data.size() !== 6) begin errors++; $display("[TB] FAIL basic_beat_count: got %0d expected 6", cap_data.size()); end
    for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
      d = cap_data[i];
      exp_last = ((i % 3) == 2);
      checks++; if (d[111:80] !== SEQ_INIT + 32'(i / 3)) begin errors++; $display("[TB] FAIL basic_seq[%0d]: got %h expected %h", i, d[111:80], SEQ_INIT + 32'(i / 3)); end
      checks++; if (d[79:64] !== 16'(i % 3)) begin errors++; $display("[TB] FAIL basic_idx[%0d]: got %0d expected %0d", i, d[79:64], i % 3); end
      checks++; if (d[63:0] !== 64'(i)) begin errors++; $display("[TB] FAIL basic_gcnt[%0d]: got %0d expected %0d", i, d[63:0], i); end
      checks++; if (cap_last[i] !== exp_last) begin errors++; $display("[TB] FAIL basic_tlast[%0d]: got %b expected %b", i, cap_last[i], exp_last); end
      checks++; if (cap_keep[i] !== (exp_last ? 14'h001F : 14'h3FFF)) begin errors++; $display("[TB] FAIL basic_tkeep[%0d]: got %h expected %h", i, cap_keep[i], exp_last ? 14'h001F : 14'h3FFF); end
      checks++; if (cap_cyc[i] !== cap_cyc[0] + i) begin errors++; $display("[TB] FAIL basic_consecutive[%0d]: got cycle %0d expected %0d", i, cap_cyc[i], cap_cyc[0] + i); end
    end
    checks++; if (pkts_sent !== 32'd2 || beats_sent !== 32'd6) begin errors++; $display("[TB] FAIL basic_counters: got %0d/%0d expected 2/6", pkts_sent, beats_sent); end
    step();
    checks++; if (done !== 1'b1 || axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL basic_hold_done: got done=%b tvalid=%b expected 1/0", done, axis.tvalid); end
    enable = 1'b0;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_to_idle: got done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_clr_priority();
    logic [111:0] d;
    configure(16'd1, 4'd14, 8'd0, 32'd1);
    clr    = 1'b1;
    enable = 1'b1;
    step();
    checks++; if (axis.tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL clr_priority_state: got tvalid=%b busy=%b expected 0/0", axis.tvalid, busy); end
    checks++; if (pkts_sent !== 32'd0 || beats_sent !== 32'd0) begin errors++; $display("[TB] FAIL clr_counters: got %0d/%0d expected 0/0", pkts_sent, beats_sent); end
    clr = 1'b0;
    step();
    d = axis.tdata;
    checks++; if (axis.tvalid !== 1'b1 || d[111:80] !== SEQ_INIT || d[63:0] !== 64'd0) begin errors++; $display("[TB] FAIL clr_restart: got tvalid=%b seq=%h gcnt=%0d expected 1/%h/0", axis.tvalid, d[111:80], d[63:0], SEQ_INIT); end
    step();
    checks++; if (done !== 1'b1 || pkts_sent !== 32'd1) begin errors++; $display("[TB] FAIL clr_single_done: got done=%b pkts=%0d expected 1/1", done, pkts_sent); end
    enable = 1'b0;
    step();
    do_clr();
  endtask

  task automatic test_stall();
    logic [111:0] pd;
    logic [13:0]  pk;
    logic         pl, pv, pr;
    logic [111:0] d;
    configure(16'd4, 4'd3, 8'd0, 32'd2);
    axis.tready = 1'b0;
    clear_capture();
    enable = 1'b1;
    pv = 1'b0; pr = 1'b0; pd = '0; pk = '0; pl = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (pv && !pr) begin
        checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== pd || axis.tkeep !== pk || axis.tlast !== pl) begin
          errors++; $display("[TB] FAIL stall_stable: got v=%b d=%h k=%h l=%b expected v=1 d=%h k=%h l=%b", axis.tvalid, axis.tdata, axis.tkeep, axis.tlast, pd, pk, pl);
        end
      end
      axis.tready = ~axis.tready;
      pv = axis.tvalid; pr = axis.tready; pd = axis.tdata; pk = axis.tkeep; pl = axis.tlast;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL stall_done: got %b expected 1", done); end
    checks++; if (cap_data.size() !== 8) begin errors++; $display("[TB] FAIL stall_beat_count: got %0d expected 8", cap_data.size()); end
    for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
      d = cap_data[i];
      checks++; if (d[79:64] !== 16'(i % 4) || cap_last[i] !== ((i % 4) == 3)) begin errors++; $display("[TB] FAIL stall_idx[%0d]: got idx=%0d last=%b expected %0d/%b", i, d[79:64], cap_last[i], i % 4, (i % 4) == 3); end
    end
    checks++; if (beats_sent !== 32'd8) begin errors++; $display("[TB] FAIL stall_beats_sent: got %0d expected 8", beats_sent); end
    enable = 1'b0;
    axis.tready = 1'b1;
    step();
    do_clr();
  endtask

  task automatic test_gap();
    logic [111:0] d0, d2, d4;
    configure(16'd2, 4'd14, 8'd5, 32'd0);
    axis.tready = 1'b1;
    clear_capture();
    enable = 1'b1;
    for (int i = 0; i < 60 && cap_data.size() < 6; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 20 && busy; i++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL gap_stop: busy got %b expected 0", busy); end
    checks++; if (cap_data.size() !== 6) begin errors++; $display("[TB] FAIL gap_beat_count: got %0d expected 6", cap_data.size()); end
    if (cap_data.size() >= 6) begin
      d0 = cap_data[0]; d2 = cap_data[2]; d4 = cap_data[4];
      checks++; if (cap_cyc[2] - cap_cyc[1] !== 6) begin errors++; $display("[TB] FAIL gap_len_1: got %0d idle expected 5", cap_cyc[2] - cap_cyc[1] - 1); end
      checks++; if (cap_cyc[4] - cap_cyc[3] !== 6) begin errors++; $display("[TB] FAIL gap_len_2: got %0d idle expected 5", cap_cyc[4] - cap_cyc[3] - 1); end
      checks++; if (cap_cyc[1] - cap_cyc[0] !== 1) begin errors++; $display("[TB] FAIL gap_in_packet: got spacing %0d expected 1", cap_cyc[1] - cap_cyc[0]); end
      checks++; if (d2[111:80] !== d0[111:80] + 32'd1 || d4[111:80] !== d0[111:80] + 32'd2) begin errors++; $display("[TB] FAIL gap_seq: got %h,%h,%h expected +1 steps", d0[111:80], d2[111:80], d4[111:80]); end
      checks++; if (d2[79:64] !== 16'd0) begin errors++; $display("[TB] FAIL gap_first_idx: got %0d expected 0", d2[79:64]); end
    end
    do_clr();
  endtask

  task automatic test_enable_drop();
    logic [111:0] d;
    configure(16'd4, 4'd14, 8'd0, 32'd0);
    axis.tready = 1'b1;
    clear_capture();
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 20 && busy; i++) step();
    checks++; if (busy !== 1'b0 || axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle: got busy=%b tvalid=%b expected 0/0", busy, axis.tvalid); end
    checks++; if (cap_data.size() !== 4) begin errors++; $display("[TB] FAIL drop_beat_count: got %0d expected 4", cap_data.size()); end
    if (cap_data.size() >= 4) begin
      d = cap_data[3];
      checks++; if (d[79:64] !== 16'd3 || cap_last[3] !== 1'b1) begin errors++; $display("[TB] FAIL drop_last_beat: got idx=%0d last=%b expected 3/1", d[79:64], cap_last[3]); end
    end
    checks++; if (pkts_sent !== 32'd1) begin errors++; $display("[TB] FAIL drop_pkts: got %0d expected 1", pkts_sent); end
    do_clr();
  endtask

  task automatic test_len0();
    logic [111:0] d;
    configure(16'd0, 4'd0, 8'd0, 32'd3);
    axis.tready = 1'b1;
    clear_capture();
    enable = 1'b1;
    for (int i = 0; i < 20 && !done; i++) step();
    checks++; if (done !== 1'b1 || pkts_sent !== 32'd3) begin errors++; $display("[TB] FAIL len0_done: got done=%b pkts=%0d expected 1/3", done, pkts_sent); end
    checks++; if (cap_data.size() !== 3) begin errors++; $display("[TB] FAIL len0_beat_count: got %0d expected 3", cap_data.size()); end
    for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
      d = cap_data[i];
      checks++; if (cap_last[i] !== 1'b1 || cap_keep[i] !== 14'h3FFF || d[79:64] !== 16'd0) begin errors++; $display("[TB] FAIL len0_beat[%0d]: got last=%b keep=%h idx=%0d expected 1/3fff/0", i, cap_last[i], cap_keep[i], d[79:64]); end
      checks++; if (d[111:80] !== SEQ_INIT + 32'(i)) begin errors++; $display("[TB] FAIL len0_seq[%0d]: got %h expected %h", i, d[111:80], SEQ_INIT + 32'(i)); end
    end
    enable = 1'b0;
    step();
    do_clr();
  endtask

  task automatic test_rst_mid();
    logic [111:0] d;
    configure(16'd4, 4'd14, 8'd0, 32'd0);
    axis.tready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++; if (pkts_sent !== 32'd1 || axis.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre: got pkts=%0d tvalid=%b expected 1/1", pkts_sent, axis.tvalid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (axis.tvalid !== 1'b0 || axis.tdata !== 112'd0) begin errors++; $display("[TB] FAIL rst_async: got tvalid=%b tdata=%h expected 0/0", axis.tvalid, axis.tdata); end
    checks++; if (pkts_sent !== 32'd0 || beats_sent !== 32'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_counters: got %0d/%0d busy=%b expected 0/0/0", pkts_sent, beats_sent, busy); end
    step();
    rst = 1'b0;
    step();
    d = axis.tdata;
    checks++; if (axis.tvalid !== 1'b1 || d[79:64] !== 16'd0 || d[111:80] !== SEQ_INIT || d[63:0] !== 64'd0) begin errors++; $display("[TB] FAIL rst_restart: got v=%b idx=%0d seq=%h gcnt=%0d expected 1/0/%h/0", axis.tvalid, d[79:64], d[111:80], d[63:0], SEQ_INIT); end
    enable = 1'b0;
    for (int i = 0; i < 10 && busy; i++) step();
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    clr         = 1'b0;
    axis.tready = 1'b1;
    configure(16'd1, 4'd14, 8'd0, 32'd0);
    test_reset();
    test_basic();
    test_clr_priority();
    test_stall();
    test_gap();
    test_enable_drop();
    test_len0();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
